// File: rtl/murax_board_pkg.sv
// rtl/murax_board_pkg.sv - shared constants and helpers for the Murax board I/O block
package murax_board_pkg;

    localparam int PWM_W   = 8;
    localparam int LED_OFS = 0;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Buttons sit directly above the LED readback bits.
    function automatic int btn_ofs(input int led_w);
        return LED_OFS + led_w;
    endfunction

endpackage

// File: rtl/murax_debounce_cell.sv
// rtl/murax_debounce_cell.sv - per-button synchroniser and debounce counter
module murax_debounce_cell
    import murax_board_pkg::*;
#(
    parameter int DB_CYCLES = 60000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic pressed_o
);

    localparam int CW = (clog2(DB_CYCLES) < 1) ? 1 : clog2(DB_CYCLES);

    logic [1:0]    sync_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          synced_pressed;

    assign synced_pressed = ~sync_q[1];

    // Count while the synced level disagrees with the accepted state; any agreement restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (synced_pressed != state_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                state_d = synced_pressed;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser flops reset to the released level so reset never reports a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_o = state_q;

endmodule

// File: rtl/murax_board_io.sv
// rtl/murax_board_io.sv - Murax board I/O: core reset stretch, button debounce, LED drive (optional MURAX_LED_PWM_EN)
module murax_board_io
    import murax_board_pkg::*;
#(
    parameter int GPIO_W     = 32,
    parameter int LED_W      = 8,
    parameter int BTN_W      = 4,
    parameter int DB_CYCLES  = 60000,
    parameter int POR_CYCLES = 4096
) (
    input  logic              io_mainClk,
    input  logic              io_asyncReset,
    input  logic [GPIO_W-1:0] io_gpio_write,
    input  logic [GPIO_W-1:0] io_gpio_writeEnable,
    output logic [GPIO_W-1:0] io_gpio_read,
    input  logic [BTN_W-1:0]  btn_n,
    output logic [LED_W-1:0]  io_led,
    output logic              io_coreReset
);

    localparam int PC      = clog2(POR_CYCLES + 1);
    localparam int BTN_OFS = btn_ofs(LED_W);

    logic [1:0]       rst_sync_q;
    logic [PC-1:0]    por_cnt_q;
    logic [PC-1:0]    por_cnt_d;
    logic             core_reset_q;
    logic [LED_W-1:0] led_q;
    logic [BTN_W-1:0] btn_pressed;
    logic             unused_gpio;

    // Hold the POR count until the release has crossed the synchroniser, then saturate at POR_CYCLES.
    always_comb begin
        por_cnt_d = por_cnt_q;
        if (rst_sync_q[1] && (por_cnt_q != PC'(POR_CYCLES))) begin
            por_cnt_d = por_cnt_q + PC'(1);
        end
    end

    // Reset stretcher: asynchronous assert, synchronous release after the full hold count.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            rst_sync_q   <= 2'b00;
            por_cnt_q    <= '0;
            core_reset_q <= 1'b1;
        end else begin
            rst_sync_q   <= {rst_sync_q[0], 1'b1};
            por_cnt_q    <= por_cnt_d;
            core_reset_q <= (por_cnt_d != PC'(POR_CYCLES));
        end
    end

    assign io_coreReset = core_reset_q;

    // LED register takes each write bit only where its enable is set.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            led_q <= '0;
        end else begin
            led_q <= io_gpio_write[LED_W-1:0] & io_gpio_writeEnable[LED_W-1:0];
        end
    end

    for (genvar g = 0; g < BTN_W; g++) begin : g_btn
        murax_debounce_cell #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_i    (io_mainClk),
            .rst_i    (io_asyncReset),
            .btn_n_i  (btn_n[g]),
            .pressed_o(btn_pressed[g])
        );
    end

    // Read map: LED readback, debounced buttons, zeros above.
    always_comb begin
        io_gpio_read                    = '0;
        io_gpio_read[LED_OFS +: LED_W]  = led_q;
        io_gpio_read[BTN_OFS +: BTN_W]  = btn_pressed;
    end

`ifdef MURAX_LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_in;

    assign duty_in = io_gpio_write[GPIO_W-1 -: PWM_W] & io_gpio_writeEnable[GPIO_W-1 -: PWM_W];

    // Free-running PWM counter; duty is sampled only on wrap so a period is never split.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            if (pwm_cnt_q == '1) begin
                duty_q <= duty_in;
            end
        end
    end

    assign io_led = led_q & {LED_W{pwm_cnt_q < duty_q}};
`else
    assign io_led = led_q;
`endif

    assign unused_gpio = ^{io_gpio_write, io_gpio_writeEnable};

endmodule

// File: doc/murax_board_io.md
Name: murax_board_io

Overview:
- Board-level I/O block between the Murax SoC and iCESugar pins, generalised over LED count, button count and GPIO width.
- Generates the core reset from io_asyncReset, using a power-on stretch with synchronous release.
- Debounces active-low push buttons into GPIO read bits and drives LEDs from GPIO write and enable bits.
- Sits in the toplevel after the SB_GB clock buffer, beside the Murax instance.

Parameters:
- GPIO_W, 32, width of the SoC GPIO bus.
- LED_W, 8, number of LED outputs; LED_W+BTN_W <= GPIO_W-8.
- BTN_W, 4, number of button inputs.
- DB_CYCLES, 60000, consecutive stable cycles required to accept a button change (5 ms at 12 MHz).
- POR_CYCLES, 4096, core-reset hold cycles after io_asyncReset release.

Ports:
- io_mainClk  in  1  system clock.
- io_asyncReset  in  1  asynchronous active-high reset.
- io_gpio_write  in  GPIO_W  SoC GPIO output values.
- io_gpio_writeEnable  in  GPIO_W  SoC GPIO output enables.
- io_gpio_read  out  GPIO_W  value presented to the SoC GPIO input.
- btn_n  in  BTN_W  raw asynchronous buttons, low = pressed.
- io_led  out  LED_W  LED drive, high = lit.
- io_coreReset  out  1  reset to Murax, active-high.

Behaviour:
- All registers reset asynchronously on io_asyncReset=1.
- Reset values: io_coreReset=1, io_led=0, io_gpio_read=0, all debounced buttons released, all counters 0.
- Reset stretcher:
  - 2-flop release synchroniser, followed by a POR counter of width clog2(POR_CYCLES+1).
  - io_coreReset deasserts exactly POR_CYCLES+2 io_mainClk edges after io_asyncReset falls, then stays 0.
  - Re-assertion of io_asyncReset mid-count sets io_coreReset=1 immediately and restarts the full count.
- Button path, per bit:
  - btn_n passes through a 2-flop synchroniser and is inverted to "pressed".
  - A debounce counter counts while the synced value differs from the debounced state.
  - On reaching DB_CYCLES-1, the debounced state flips on the next edge and the counter clears.
  - Any cycle where synced equals debounced clears the counter, so a glitch shorter than DB_CYCLES is never reported.
  - Total press latency from pin to read bit is DB_CYCLES+2 cycles.
- io_gpio_read mapping (combinational from registers):
  - [LED_W-1:0] = io_led readback.
  - [LED_W+BTN_W-1:LED_W] = debounced pressed.
  - All other bits 0.
- LED drive:
  - io_led[i] is registered from io_gpio_write[i] & io_gpio_writeEnable[i], giving 1-cycle latency.
  - A bit with its enable low is driven 0.
- io_coreReset=1 does not hold this block in reset; only io_asyncReset resets it.

Optional Feature:
- Macro: MURAX_LED_PWM_EN.
- When defined:
  - A free-running 8-bit pwm_cnt increments every cycle from 0.
  - duty = io_gpio_write[GPIO_W-1:GPIO_W-8], qualified by the matching enable bits (a disabled bit counts as 0).
  - io_led[i] = led_reg[i] & (pwm_cnt < duty).
  - duty=0 gives always off; duty=0x80 gives 128 of every 256 cycles lit; duty=0xFF gives 255 of 256.
  - A duty change takes effect at the next pwm_cnt wrap (0xFF to 0x00), so no partial-period glitch occurs.
  - Readback in io_gpio_read reports led_reg, not the PWM output.
- When undefined: no pwm_cnt exists, and io_led=led_reg.

Decomposition:
- Package murax_board_pkg holds:
  - the clog2 function;
  - read-map offset constants LED_OFS=0 and BTN_OFS=LED_W;
  - PWM_W=8.
- Sub-module murax_debounce_cell holds one synchroniser plus counter plus state, parametrised by DB_CYCLES and instantiated BTN_W times with a generate loop.

Test Plan (bench uses DB_CYCLES=16, POR_CYCLES=32):
- Reset release: drop io_asyncReset at t0 -> io_coreReset=1 through edge 33 and 0 from edge 34; re-assert at edge 20 -> io_coreReset=1 immediately and the count restarts.
- Clean press: btn_n[0] goes 1->0 and is held -> io_gpio_read[8]=1 exactly 18 cycles later; release -> back to 0 after 18 cycles.
- Bounce: btn_n[1] toggles every 5 cycles for 60 cycles, then stays low -> io_gpio_read[9] stays 0 until 18 cycles after the last toggle.
- LED enable masking: write=0x000000A5, enable=0x0000000F -> io_led=0x05 one cycle later and io_gpio_read[7:0]=0x05.
- Mid-operation reset: io_asyncReset pulse during a held press and with io_led=0xFF -> io_led=0, debounced state 0, and re-detection 18 cycles after release.
- MURAX_LED_PWM_EN: led_reg=0x01, write[31:24]=0x40 -> io_led[0] high for 64 of every 256 cycles; change to 0xC0 mid-period -> the new duty starts only at the next wrap.
